// File: rtl/ls_pkg.sv
// Shared definitions for the load/store alignment unit: size codes,
// sequencer states and the lane-index width helper.
package ls_pkg;

    localparam logic [1:0] LS_BYTE  = 2'b00;
    localparam logic [1:0] LS_HALF  = 2'b01;
    localparam logic [1:0] LS_WORD  = 2'b10;
    localparam logic [1:0] LS_DWORD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_WRITE,
        ST_RESP
    } ls_state_e;

    // Number of address bits selecting a byte lane inside one memory word.
    function automatic int lane_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/ls_lane_mux.sv
// Combinational lane logic: extracts and extends a loaded sub-word, and
// merges store data into a previously read word. Both paths share the same
// lane shift and size mask.
module ls_lane_mux
    import ls_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]         word,
    input  logic [DATA_W-1:0]         wdata,
    input  logic [lane_w(DATA_W)-1:0] off,
    input  logic [1:0]                size,
    input  logic                      sgn,
    output logic [DATA_W-1:0]         ext,
    output logic [DATA_W-1:0]         merged
);

    localparam int SW = $clog2(DATA_W);

    logic [SW:0]       nbits;
    logic [SW-1:0]     sh;
    logic [SW-1:0]     sign_idx;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] shifted;
    logic              sign_bit;

    // Shared lane decode: access width in bits, bit offset of the lane, and a low-justified mask.
    always_comb begin
        nbits = (SW+1)'(DATA_W);
        case (size)
            LS_BYTE: nbits = (SW+1)'(8);
            LS_HALF: nbits = (SW+1)'(16);
            LS_WORD: nbits = (SW+1)'(32);
            default: nbits = (SW+1)'(DATA_W);
        endcase
        sh       = {off, 3'b000};
        sign_idx = SW'(nbits - 1'b1);
        mask     = (nbits == (SW+1)'(DATA_W)) ? '1 : ~({DATA_W{1'b1}} << nbits);
    end

    // Load path: right-justify the lane, then sign- or zero-extend.
    always_comb begin
        shifted  = word >> sh;
        sign_bit = shifted[sign_idx];
        ext      = (sgn && sign_bit) ? (shifted | ~mask) : (shifted & mask);
    end

    // Store path: replace only the addressed lane(s) of the read word.
    always_comb begin
        merged = (word & ~(mask << sh)) | ((wdata & mask) << sh);
    end

endmodule

// File: rtl/ls_align_unit.sv
// Load/store alignment sequencer between the control unit and data memory.
// Issues aligned word accesses, performs read-modify-write for sub-word
// stores and reports misaligned/illegal requests without touching memory.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | req_ready high, waiting for a request
// ST_READ  | mem_rd strobe for a load or sub-word store
// ST_WAIT  | MEM_LAT cycles of read latency; data used on the last one
// ST_WRITE | mem_wr strobe with full or merged word
// ST_RESP  | rsp_valid pulse, then back to idle
module ls_align_unit
    import ls_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error
);

    localparam int LW = lane_w(DATA_W);
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    ls_state_e         state, state_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic              lat_write, lat_signed;
    logic [1:0]        lat_size;
    logic [LW-1:0]     lat_off;
    logic [DATA_W-1:0] lat_wdata;
    logic              latch_en;

    logic              mem_rd_nx, mem_wr_nx, rsp_valid_nx, rsp_error_nx;
    logic [ADDR_W-1:0] mem_addr_nx;
    logic [DATA_W-1:0] mem_wdata_nx, rsp_rdata_nx;

    logic              accept, req_err, req_full;
    logic [DATA_W-1:0] ext, merged;

    ls_lane_mux #(.DATA_W(DATA_W)) u_lane (
        .word   (mem_rdata),
        .wdata  (lat_wdata),
        .off    (lat_off),
        .size   (lat_size),
        .sgn    (lat_signed),
        .ext    (ext),
        .merged (merged)
    );

    // Classify the incoming request: legality/alignment and whether a store covers the whole word.
    always_comb begin
        accept   = req_valid && req_ready;
        req_full = (DATA_W == 32) ? (req_size == LS_WORD) : (req_size == LS_DWORD);
        case (req_size)
            LS_HALF:  req_err = req_addr[0];
            LS_WORD:  req_err = |req_addr[1:0];
            LS_DWORD: req_err = (DATA_W == 32) || (|req_addr[2:0]);
            default:  req_err = 1'b0;
        endcase
    end

    // Next state and next registered outputs.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        latch_en     = 1'b0;
        mem_rd_nx    = 1'b0;
        mem_wr_nx    = 1'b0;
        mem_addr_nx  = mem_addr;
        mem_wdata_nx = mem_wdata;
        rsp_valid_nx = 1'b0;
        rsp_rdata_nx = '0;
        rsp_error_nx = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    latch_en = 1'b1;
                    if (req_err) begin
                        state_nx     = ST_RESP;
                        rsp_valid_nx = 1'b1;
                        rsp_error_nx = 1'b1;
                    end else begin
                        mem_addr_nx = {req_addr[ADDR_W-1:LW], {LW{1'b0}}};
                        if (req_write && req_full) begin
                            state_nx     = ST_WRITE;
                            mem_wr_nx    = 1'b1;
                            mem_wdata_nx = req_wdata;
                        end else begin
                            state_nx  = ST_READ;
                            mem_rd_nx = 1'b1;
                        end
                    end
                end
            end
            ST_READ: begin
                state_nx = ST_WAIT;
                cnt_nx   = CW'(MEM_LAT - 1);
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    if (lat_write) begin
                        state_nx     = ST_WRITE;
                        mem_wr_nx    = 1'b1;
                        mem_wdata_nx = merged;
                    end else begin
                        state_nx     = ST_RESP;
                        rsp_valid_nx = 1'b1;
                        rsp_rdata_nx = ext;
                    end
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            ST_WRITE: begin
                state_nx     = ST_RESP;
                rsp_valid_nx = 1'b1;
            end
            ST_RESP: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // State, request latch and registered outputs; reset aborts everything.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            lat_write  <= 1'b0;
            lat_signed <= 1'b0;
            lat_size   <= LS_BYTE;
            lat_off    <= '0;
            lat_wdata  <= '0;
            req_ready  <= 1'b0;
            mem_addr   <= '0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_wdata  <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_error  <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            if (latch_en) begin
                lat_write  <= req_write;
                lat_signed <= req_signed;
                lat_size   <= req_size;
                lat_off    <= req_addr[LW-1:0];
                lat_wdata  <= req_wdata;
            end
            req_ready <= (state_nx == ST_IDLE);
            mem_addr  <= mem_addr_nx;
            mem_rd    <= mem_rd_nx;
            mem_wr    <= mem_wr_nx;
            mem_wdata <= mem_wdata_nx;
            rsp_valid <= rsp_valid_nx;
            rsp_rdata <= rsp_rdata_nx;
            rsp_error <= rsp_error_nx;
        end
    end

endmodule

// File: tb/tb_ls_align_unit.sv
// Self-checking bench for ls_align_unit (DATA_W=32, MEM_LAT=2) against a
// byte-addressed reference memory model.
module tb_ls_align_unit;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int MEM_LAT = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [1:0]        req_size = 2'b00;
    logic              req_signed = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_error;

    int errors = 0;
    int checks = 0;

    logic [31:0] tmem [0:255];
    logic [7:0]  mb   [0:1023];
    int          wr_seen = 0;
    int          cd = 0;
    logic        pend = 1'b0;
    logic [7:0]  pidx = '0;

    ls_align_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_error  (rsp_error)
    );

    always #5 clock = ~clock;

    // Word memory: writes on mem_wr, read data valid exactly MEM_LAT cycles after mem_rd, garbage otherwise.
    always @(posedge clock) begin
        logic drive;
        drive = 1'b0;
        if (mem_wr) begin
            tmem[mem_addr[9:2]] = mem_wdata;
            wr_seen++;
        end
        if (mem_rd) begin
            pidx = mem_addr[9:2];
            cd   = MEM_LAT - 1;
            pend = 1'b1;
        end else if (cd > 0) begin
            cd--;
        end
        if (pend && cd == 0) begin
            drive = 1'b1;
            pend  = 1'b0;
        end
        #1;
        mem_rdata = drive ? tmem[pidx] : $urandom;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_word(input int a);
        int b;
        b = a & ~3;
        return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
    endfunction

    task automatic set_word(input int a, input logic [31:0] v);
        int b;
        b = a & ~3;
        tmem[b >> 2] = v;
        for (int i = 0; i < 4; i++) mb[b+i] = v[8*i +: 8];
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ready"}, req_ready, 0);
        chk({tag, "_rd"},    mem_rd, 0);
        chk({tag, "_wr"},    mem_wr, 0);
        chk({tag, "_addr"},  mem_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_rvld"},  rsp_valid, 0);
        chk({tag, "_rdata"}, rsp_rdata, 0);
        chk({tag, "_rerr"},  rsp_error, 0);
    endtask

    // One complete transaction, checked against the byte-level model.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd, output logic [31:0] got_data);
        int          nb, lat_exp, lat, rd_n, wr_n, rd_cyc, wr_cyc, n;
        logic        err, both, got;
        logic [31:0] exp_data, exp_word, aligned, rd_addr, wr_addr, wr_dat;
        longint      v;

        nb      = 1 << sz;
        aligned = a & ~32'h3;
        err     = (sz == 2'b11) || (a % nb != 0);
        if (err)          lat_exp = 1;
        else if (w)       lat_exp = (sz == 2'b10) ? 2 : 3 + MEM_LAT;
        else              lat_exp = 2 + MEM_LAT;

        exp_data = 0;
        if (!err && !w) begin
            v = 0;
            for (int i = 0; i < nb; i++) v += longint'(mb[a+i]) << (8*i);
            if (sg && v >= (longint'(1) << (8*nb - 1))) v -= longint'(1) << (8*nb);
            exp_data = 32'(v);
        end
        if (!err && w) for (int i = 0; i < nb; i++) mb[a+i] = wd[8*i +: 8];
        exp_word = model_word(a);

        n = 0;
        @(negedge clock);
        while (!req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("ready_before_req", req_ready, 1);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        @(posedge clock);
        #1;
        req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
        req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;

        rd_n = 0; wr_n = 0; rd_cyc = -1; wr_cyc = -1; lat = -1;
        rd_addr = 0; wr_addr = 0; wr_dat = 0; both = 1'b0; got = 1'b0; got_data = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (mem_rd && mem_wr) both = 1'b1;
            if (mem_rd) begin rd_n++; rd_cyc = c; rd_addr = mem_addr; end
            if (mem_wr) begin wr_n++; wr_cyc = c; wr_addr = mem_addr; wr_dat = mem_wdata; end
            if (rsp_valid) begin
                lat = c; got = 1'b1; got_data = rsp_rdata;
                chk("ready_in_resp", req_ready, 0);
                chk("rsp_error", rsp_error, err);
                chk("rsp_rdata", rsp_rdata, exp_data);
                break;
            end
        end
        chk("latency", 64'(lat), 64'(lat_exp));
        chk("rd_wr_overlap", both, 0);
        chk("rd_count", 64'(rd_n), (err || (w && sz == 2'b10)) ? 64'd0 : 64'd1);
        chk("wr_count", 64'(wr_n), (!err && w) ? 64'd1 : 64'd0);
        if (rd_n == 1) begin
            chk("rd_cycle", 64'(rd_cyc), 64'd1);
            chk("rd_addr", rd_addr, aligned);
        end
        if (wr_n == 1) begin
            chk("wr_cycle", 64'(wr_cyc), (sz == 2'b10) ? 64'd1 : 64'(2 + MEM_LAT));
            chk("wr_addr", wr_addr, aligned);
            chk("wr_data", wr_dat, exp_word);
        end
        @(negedge clock);
        chk("rsp_pulse_one", rsp_valid, 0);
        chk("mem_word", tmem[(a & 32'h3FF) >> 2], exp_word);
    endtask

    initial begin
        logic [31:0] r;
        int          w0;

        for (int i = 0; i < 256; i++) set_word(i * 4, $urandom);

        repeat (2) @(negedge clock);
        chk_outputs_zero("reset");
        reset = 1'b1;
        #1 chk("ready_at_release", req_ready, 0);
        @(negedge clock);
        chk("ready_after_release", req_ready, 1);

        set_word(32'h100, 32'h80123456);
        do_req(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, r);
        chk("plan_signed_byte", r, 32'hFFFFFF80);
        do_req(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, r);
        chk("plan_unsigned_half", r, 32'h00008012);
        do_req(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, r);
        chk("signed_half", r, 32'hFFFF8012);

        set_word(32'h100, 32'h11223344);
        do_req(1'b1, 2'b00, 1'b0, 32'h101, 32'hAABBCCDD, r);
        chk("plan_byte_store", tmem[32'h100 >> 2], 32'h1122DD44);
        do_req(1'b1, 2'b10, 1'b0, 32'h200, 32'hCAFEF00D, r);
        chk("plan_word_store", tmem[32'h200 >> 2], 32'hCAFEF00D);
        do_req(1'b0, 2'b01, 1'b0, 32'h101, 32'h0, r);
        do_req(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, r);
        do_req(1'b1, 2'b10, 1'b0, 32'h102, 32'h12345678, r);

        for (int k = 0; k < 300; k++) begin
            do_req(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                   32'h100 + 32'($urandom_range(0, 63)), $urandom, r);
        end

        // Reset during WAIT of a byte store must discard the write.
        set_word(32'h120, 32'h55667788);
        @(negedge clock);
        chk("ready_before_abort", req_ready, 1);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h122; req_wdata = 32'h000000EE;
        @(posedge clock);
        #1 req_valid = 1'b0;
        w0 = wr_seen;
        @(negedge clock);
        chk("abort_rd_strobe", mem_rd, 1);
        @(negedge clock);
        reset = 1'b0;
        #1 chk_outputs_zero("abort");
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("abort_no_wr", mem_wr, 0);
        end
        reset = 1'b1;
        #1 chk("abort_ready_release", req_ready, 0);
        @(negedge clock);
        chk("abort_ready_back", req_ready, 1);
        chk("abort_wr_count", 64'(wr_seen), 64'(w0));
        chk("abort_mem_word", tmem[32'h120 >> 2], 32'h55667788);
        do_req(1'b0, 2'b10, 1'b0, 32'h120, 32'h0, r);
        chk("after_abort_load", r, 32'h55667788);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
